// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the instruction fetch slice
package cpu_pkg;

   localparam int INSTR_W = 32;

   // Fetch FSM encodings
   localparam logic [1:0] IF_IDLE = 2'd0;
   localparam logic [1:0] IF_REQ  = 2'd1;
   localparam logic [1:0] IF_HOLD = 2'd2;

   localparam logic [INSTR_W-1:0] NOP_CMD = 32'h0000_0000;
   localparam logic [31:0]        PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      S_IDLE = IF_IDLE,
      S_REQ  = IF_REQ,
      S_HOLD = IF_HOLD
   } if_state_t;

   // Clear the byte offset so every PC stays word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch unit bus bundle (imem, decode and execute sides)
interface instr_fetch_if;
   import cpu_pkg::*;

   logic               imem_req;
   logic [31:0]        imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   logic [INSTR_W-1:0] cmd;
   logic [31:0]        cmd_pc;
   logic               cmd_valid;
   logic               cmd_ready;

   logic               redirect;
   logic [31:0]        redirect_pc;
   logic               halt;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output cmd, cmd_pc, cmd_valid,
      input  cmd_ready,
      input  redirect, redirect_pc, halt
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  cmd, cmd_pc, cmd_valid,
      output cmd_ready,
      output redirect, redirect_pc, halt
   );

endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC holder and fetch FSM feeding decode with one instruction at a time
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_CMD  = cpu_pkg::NOP_CMD
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_fetch_if.master fb
);
   import cpu_pkg::*;

   if_state_t          state;
   logic [31:0]        pc;
   logic [31:0]        redir_pc;
   logic               discard;
   logic [INSTR_W-1:0] cmd_q;
   logic [31:0]        cmd_pc_q;
   logic               cmd_valid_q;
   logic [31:0]        target;

   // Redirect target with the byte offset forced to zero
   assign target = word_align(fb.redirect_pc);

   // Outputs come only from registers or the state decode
   assign fb.imem_req  = (state == S_REQ);
   assign fb.imem_addr = pc;
   assign fb.cmd       = cmd_q;
   assign fb.cmd_pc    = cmd_pc_q;
   assign fb.cmd_valid = cmd_valid_q;

   // Fetch FSM: issue request, capture instruction, hold it until decode takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         redir_pc    <= RESET_PC;
         discard     <= 1'b0;
         cmd_q       <= NOP_CMD;
         cmd_pc_q    <= RESET_PC;
         cmd_valid_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fb.redirect) begin
                  pc <= target;
               end
               if (!fb.halt) begin
                  state <= S_REQ;
               end
            end

            S_REQ: begin
               if (fb.imem_ack) begin
                  if (discard || fb.redirect) begin
                     // Stale data from before a redirect: drop it and restart at the target.
                     // A redirect arriving with the ack is newer than any saved target.
                     discard <= 1'b0;
                     pc      <= fb.redirect ? target : redir_pc;
                     state   <= fb.halt ? S_IDLE : S_REQ;
                  end else begin
                     cmd_q       <= fb.imem_rdata;
                     cmd_pc_q    <= pc;
                     cmd_valid_q <= 1'b1;
                     pc          <= pc + PC_STEP;
                     state       <= S_HOLD;
                  end
               end else if (fb.redirect) begin
                  // The request stays on the bus; remember where to go once it returns
                  discard  <= 1'b1;
                  redir_pc <= target;
               end
            end

            S_HOLD: begin
               if (fb.redirect) begin
                  // Either the held word is the branch itself (ready) or it is squashed
                  cmd_valid_q <= 1'b0;
                  cmd_q       <= NOP_CMD;
                  pc          <= target;
                  state       <= fb.halt ? S_IDLE : S_REQ;
               end else if (fb.cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  cmd_q       <= NOP_CMD;
                  state       <= fb.halt ? S_IDLE : S_REQ;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic force_ack = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int pops = 0;
   int cyc = 0;
   int unsigned wait_cnt = 0;

   logic [31:0] sb_q[$];
   logic [31:0] req_log[$];
   logic [31:0] log2[$];
   int          pop_cyc[$];

   instr_fetch_if bus ();
   instr_fetch_if bus2 ();

   instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_CMD(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fb    (bus.master)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_CMD(32'h0000_0000)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .fb    (bus2.master)
   );

   always #5 clk = ~clk;

   // second instance: memory always answers at once, decode always ready
   assign bus2.imem_ack    = bus2.imem_req;
   assign bus2.imem_rdata  = 32'h0000_0013;
   assign bus2.cmd_ready   = 1'b1;
   assign bus2.redirect    = 1'b0;
   assign bus2.redirect_pc = 32'h0;
   assign bus2.halt        = 1'b0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return 32'h2002_0005 + a - 32'h0000_0100;
   endfunction

   function automatic int unsigned delay_of(input logic [31:0] a);
      case (a)
         32'h0000_0008: return 3;
         32'h0000_0010: return 2;
         32'h0000_0044: return 3;
         default:       return 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // instruction memory model with per-address ack latency
   always @(negedge clk) begin
      #1;
      if (bus.imem_req) begin
         if (wait_cnt == delay_of(bus.imem_addr)) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_data(bus.imem_addr);
            wait_cnt       = 0;
         end else begin
            bus.imem_ack   = force_ack;
            bus.imem_rdata = 32'hDEAD_BEEF;
            wait_cnt++;
         end
      end else begin
         bus.imem_ack   = force_ack;
         bus.imem_rdata = 32'hDEAD_BEEF;
         wait_cnt       = 0;
      end
   end

   // monitor: request log and scoreboard pop on each decode handshake
   always @(negedge clk) begin
      logic [31:0] e;
      #2;
      cyc++;
      if (bus.imem_req) req_log.push_back(bus.imem_addr);
      if (bus2.imem_req) log2.push_back(bus2.imem_addr);
      if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_unexpected observed cmd_pc=%h cmd=%h expected none", bus.cmd_pc, bus.cmd);
         end else begin
            e = sb_q.pop_front();
            chk("sb_pc", {32'h0, bus.cmd_pc}, {32'h0, e});
            chk("sb_cmd", {32'h0, bus.cmd}, {32'h0, mem_data(e)});
            pops++;
            pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic wait_req(input logic [31:0] a);
      int k = 0;
      while (!(bus.imem_req === 1'b1 && bus.imem_addr === a) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("wait_req", {31'h0, bus.imem_req, bus.imem_addr}, {31'h0, 1'b1, a});
   endtask

   task automatic wait_req_any(output logic [31:0] a);
      int k = 0;
      while (bus.imem_req !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("wait_req_any", {63'h0, bus.imem_req}, 64'h1);
      a = bus.imem_addr;
   endtask

   task automatic wait_valid();
      int k = 0;
      while (bus.cmd_valid !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("wait_valid", {63'h0, bus.cmd_valid}, 64'h1);
   endtask

   task automatic wait_deliv(input int n);
      int k = 0;
      while (pops < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("deliv_count", 64'(pops), 64'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      bus.cmd_ready   = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.halt        = 1'b0;
      repeat (2) @(negedge clk);

      // reset values
      chk("rst_req", {63'h0, bus.imem_req}, 64'h0);
      chk("rst_addr", {32'h0, bus.imem_addr}, 64'h0);
      chk("rst_cmd", {32'h0, bus.cmd}, 64'h0);
      chk("rst_cmd_pc", {32'h0, bus.cmd_pc}, 64'h0);
      chk("rst_valid", {63'h0, bus.cmd_valid}, 64'h0);
      chk("rst2_addr", {32'h0, bus2.imem_addr}, 64'hFFFF_FFFC);

      // sequential fetch with a slow ack at 0x8
      sb_q.push_back(32'h0);
      sb_q.push_back(32'h4);
      sb_q.push_back(32'h8);
      sb_q.push_back(32'hC);
      rst_n = 1'b1;
      wait_deliv(4);

      // redirect to 0x103 while 0x10 is in flight
      wait_req(32'h10);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0103;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("redir_hold_req", {63'h0, bus.imem_req}, 64'h1);
      chk("redir_hold_addr", {32'h0, bus.imem_addr}, 64'h10);
      sb_q.push_back(32'h100);
      wait_req(32'h100);
      bus.cmd_ready = 1'b0;

      // decode stalls for five cycles
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         chk("stall_cmd", {32'h0, bus.cmd}, 64'h2002_0005);
         chk("stall_cmd_pc", {32'h0, bus.cmd_pc}, 64'h100);
         chk("stall_valid", {63'h0, bus.cmd_valid}, 64'h1);
         chk("stall_no_req", {63'h0, bus.imem_req}, 64'h0);
         @(negedge clk);
      end
      bus.cmd_ready = 1'b1;
      wait_req_any(a);
      chk("after_stall_addr", {32'h0, a}, 64'h104);
      bus.cmd_ready = 1'b0;
      sb_q.push_back(32'h104);

      // redirect to 0x40 together with the handshake in HOLD
      wait_valid();
      chk("hold_pc", {32'h0, bus.cmd_pc}, 64'h104);
      bus.cmd_ready   = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0040;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      bus.redirect  = 1'b0;
      chk("jmp_req", {63'h0, bus.imem_req}, 64'h1);
      chk("jmp_addr", {32'h0, bus.imem_addr}, 64'h40);
      chk("jmp_valid", {63'h0, bus.cmd_valid}, 64'h0);
      sb_q.push_back(32'h40);

      // halt raised while holding an instruction
      wait_valid();
      chk("halt_hold_pc", {32'h0, bus.cmd_pc}, 64'h40);
      bus.halt      = 1'b1;
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      chk("halt_valid", {63'h0, bus.cmd_valid}, 64'h0);
      for (int i = 0; i < 4; i++) begin
         chk("halt_no_req", {63'h0, bus.imem_req}, 64'h0);
         @(negedge clk);
      end
      bus.halt = 1'b0;
      wait_req_any(a);
      chk("resume_addr", {32'h0, a}, 64'h44);

      // asynchronous reset in the middle of the 0x44 request
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_req", {63'h0, bus.imem_req}, 64'h0);
      chk("arst_addr", {32'h0, bus.imem_addr}, 64'h0);
      chk("arst_valid", {63'h0, bus.cmd_valid}, 64'h0);
      chk("arst_cmd", {32'h0, bus.cmd}, 64'h0);
      chk("arst_cmd_pc", {32'h0, bus.cmd_pc}, 64'h0);
      force_ack = 1'b1;
      bus.halt  = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_ack_valid", {63'h0, bus.cmd_valid}, 64'h0);
         chk("late_ack_req", {63'h0, bus.imem_req}, 64'h0);
      end
      force_ack = 1'b0;
      @(negedge clk);

      // logs and scoreboard drain
      chk("total_pops", 64'(pops), 64'd7);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      chk("req_log_len", 64'(req_log.size() >= 7), 64'd1);
      if (req_log.size() >= 7) begin
         chk("req_log0", {32'h0, req_log[0]}, 64'h0);
         chk("req_log1", {32'h0, req_log[1]}, 64'h4);
         chk("req_log2", {32'h0, req_log[2]}, 64'h8);
         chk("req_log3", {32'h0, req_log[3]}, 64'h8);
         chk("req_log4", {32'h0, req_log[4]}, 64'h8);
         chk("req_log5", {32'h0, req_log[5]}, 64'h8);
         chk("req_log6", {32'h0, req_log[6]}, 64'hC);
      end
      chk("pop_cyc_len", 64'(pop_cyc.size() >= 2), 64'd1);
      if (pop_cyc.size() >= 2) begin
         chk("cadence", 64'(pop_cyc[1] - pop_cyc[0]), 64'd2);
      end
      chk("log2_len", 64'(log2.size() >= 3), 64'd1);
      if (log2.size() >= 3) begin
         chk("wrap_fetch0", {32'h0, log2[0]}, 64'hFFFF_FFFC);
         chk("wrap_fetch1", {32'h0, log2[1]}, 64'h0);
         chk("wrap_fetch2", {32'h0, log2[2]}, 64'h4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetches 32-bit instructions from instruction memory and delivers them to the control unit's `cmd` input.
- Holds the PC and runs a req/ack handshake toward instruction memory.
- Presents each fetched instruction with a valid/ready handshake toward decode.
- Accepts branch/jump redirects and a halt from the execute side.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- NOP_CMD, 32'h0000_0000, value driven on `cmd` whenever `cmd_valid` = 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  memory has returned data on `imem_rdata` this cycle.
- imem_rdata  in  32  instruction word, sampled only when `imem_req` & `imem_ack`.
- cmd  out  32  instruction to the control unit.
- cmd_pc  out  32  address of the instruction on `cmd`.
- cmd_valid  out  1  `cmd` / `cmd_pc` hold a live instruction.
- cmd_ready  in  1  decode accepts `cmd` this cycle.
- redirect  in  1  load a new PC (taken branch/jump).
- redirect_pc  in  32  target; bits [1:0] are ignored and treated as 0.
- halt  in  1  level; stop issuing new fetches while high.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, pc = RESET_PC.
  - imem_req = 0, imem_addr = RESET_PC.
  - cmd = NOP_CMD, cmd_pc = RESET_PC, cmd_valid = 0.
  - discard = 0.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- imem_req = (state == REQ); imem_addr = pc.
  - While in REQ, both stay stable until ack.
- FSM states: IDLE, REQ, HOLD.
  - IDLE -> REQ when halt = 0.
  - IDLE: a redirect loads pc = {redirect_pc[31:2], 2'b00}.
  - REQ, imem_ack = 1, discard = 0:
    - cmd <= imem_rdata, cmd_pc <= pc, cmd_valid <= 1.
    - pc <= pc + 4.
    - Go to HOLD.
  - REQ, imem_ack = 1, discard = 1:
    - Drop the data; discard <= 0.
    - pc <= saved redirect target.
    - Go to REQ, or to IDLE if halt.
  - REQ, imem_ack = 0: stay.
  - HOLD, cmd_ready = 1:
    - cmd_valid <= 0, cmd <= NOP_CMD.
    - Go to REQ, or to IDLE if halt.
  - HOLD, cmd_ready = 0: stay; cmd, cmd_pc and cmd_valid are stable.
- Latency:
  - Ack in the same cycle as req gives cmd_valid on the next edge.
  - Peak throughput is 1 instruction per 2 cycles.
- Redirect rules (priority over sequential PC):
  - In REQ: an in-flight request is never aborted. Set discard, latch the target into the redirect register, keep imem_addr unchanged until ack.
  - In REQ with redirect and ack in the same cycle: data is dropped, next state REQ at the target; discard is not left set.
  - Multiple redirects while discard is set: the last target wins.
  - In HOLD without cmd_ready: held instruction is squashed; cmd_valid <= 0, pc <= target, go to REQ.
  - In HOLD with cmd_ready in the same cycle: the handshake completes (the instruction is the branch itself), pc <= target, go to REQ.
- Halt:
  - Never cancels an in-flight request or a held instruction.
  - Only gates the transitions into REQ.
  - Deasserting halt resumes from the current pc.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- imem_ack while imem_req = 0 is ignored.
- Reset mid-transaction: return immediately to reset values; the pending memory ack is ignored because req = 0.

Decomposition:
- Package cpu_pkg:
  - state encoding localparams IF_IDLE/IF_REQ/IF_HOLD (2-bit).
  - NOP_CMD value.
  - PC_STEP = 4.
  - INSTR_W = 32.
- No sub-module is required.
- The PC register with redirect mux, pc_reg, is the natural split if pc is reused by the branch unit.

Test Plan:
- Reset then release, memory acks every cycle at the same cycle as req, cmd_ready = 1 -> imem_addr sequence 0, 4, 8, C; cmd_valid pulses every 2nd cycle; cmd_pc matches address.
- Ack delayed 3 cycles at addr 8 -> imem_req/imem_addr held 4 cycles at 32'h8; exactly one cmd delivered with cmd_pc = 8.
- cmd_ready = 0 for 5 cycles with cmd = 32'h2002_0005 -> cmd/cmd_pc/cmd_valid unchanged, no new imem_req; after ready, next fetch at cmd_pc + 4.
- Redirect to 32'h0000_0103 during a pending req at 32'h10, ack 2 cycles later -> data at 0x10 never appears on cmd; next req at 32'h100.
- Redirect to 32'h40 coincident with cmd_ready in HOLD -> held cmd accepted once; next imem_addr = 32'h40.
- RESET_PC = 32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
- halt high in HOLD -> after cmd_ready, no imem_req until halt low.
- rst_n pulsed low mid-REQ -> outputs at reset values asynchronously; late ack produces no cmd.
